// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch PC block.
// Holds the next-PC select encodings, the controller states and the
// default reset/base PC of the legal fetch window.
package fetch_pc_pkg;

  // npc_sel encodings
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,  // PC+4
    NPC_BR  = 2'b01,  // conditional word-offset branch
    NPC_J   = 2'b10,  // region jump with 26-bit word index
    NPC_JR  = 2'b11   // register-indirect jump
  } npc_sel_e;

  // controller states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/fetch_pc_npc_calc.sv
// npc_calc: purely combinational next-PC target and legality check.
// Ports:
//   pc, pc4        current PC and PC+4
//   npc_sel        next-PC source select (see fetch_pc_pkg)
//   br_taken       branch condition, used only for NPC_BR
//   imm16          signed branch offset in words
//   imm26          jump target field
//   rs_val         register jump target
//   target         computed next PC
//   legal          target is word aligned and inside the fetch window
module npc_calc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] target,
  output logic        legal
);

  // Window end computed in 33 bits so a window touching 2^32 does not wrap.
  localparam logic [32:0] WIN_END = {1'b0, PC_RESET} + 33'(IM_WORDS) * 33'd4;

  logic [31:0] br_off;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = pc4;
    case (npc_sel)
      NPC_SEQ: target = pc4;
      NPC_BR:  target = br_taken ? (pc4 + br_off) : pc4;
      NPC_J:   target = {pc4[31:28], imm26, 2'b00};
      NPC_JR:  target = rs_val;
      default: target = pc4;
    endcase
  end

  assign legal = (target[1:0] == 2'b00) &&
                 (target >= PC_RESET) &&
                 ({1'b0, target} < WIN_END);

  // pc is carried for readability of the interface; only pc4 feeds targets.
  logic unused_pc;
  assign unused_pc = ^pc;

endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: instruction fetch program counter with a sticky fault state.
// PC advances to the computed target each unstalled cycle while the target
// is legal; an illegal target freezes PC and latches pc_fault until reset.
// Optional feature: define FETCH_PC_CNT_EN to add the fetch_cnt port, a
// wrapping count of PC updates.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   stall          hold PC (no legality check while high)
//   npc_sel        next-PC source select
//   br_taken, imm16, imm26, rs_val   target operands
//   PC, PC4        current fetch address and PC+4 (register-only outputs)
//   pc_fault       sticky fault flag
//   fetch_cnt      update counter (FETCH_PC_CNT_EN only)
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] PC,
  output logic [31:0] PC4,
`ifdef FETCH_PC_CNT_EN
  output logic [31:0] fetch_cnt,
`endif
  output logic        pc_fault
);

  state_e      state;
  logic [31:0] pc_q;
  logic [31:0] target;
  logic        legal;

  assign PC  = pc_q;
  assign PC4 = pc_q + 32'd4;

  npc_calc #(
    .PC_RESET (PC_RESET),
    .IM_WORDS (IM_WORDS)
  ) u_npc_calc (
    .pc       (pc_q),
    .pc4      (PC4),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .imm26    (imm26),
    .rs_val   (rs_val),
    .target   (target),
    .legal    (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= PC_RESET;
      state    <= ST_RUN;
      pc_fault <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          // Stall outranks the legality check: nothing moves, nothing faults.
          if (!stall) begin
            if (legal) begin
              pc_q <= target;
            end else begin
              pc_fault <= 1'b1;
              state    <= ST_FAULT;
            end
          end
        end
        default: ; // ST_FAULT: frozen until reset
      endcase
    end
  end

`ifdef FETCH_PC_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      fetch_cnt <= 32'd0;
    else if (state == ST_RUN && !stall && legal)
      fetch_cnt <= fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Directed testbench for fetch_pc with a behavioural reference model and a
// per-cycle compare process, plus literal expectations on key points.
module tb_fetch_pc;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] imm26 = 26'h0;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] PC, PC4;
  logic        pc_fault;
`ifdef FETCH_PC_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  fetch_pc #(.PC_RESET(BASE), .IM_WORDS(WORDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .imm26    (imm26),
    .rs_val   (rs_val),
    .PC       (PC),
    .PC4      (PC4),
`ifdef FETCH_PC_CNT_EN
    .fetch_cnt(fetch_cnt),
`endif
    .pc_fault (pc_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: next address from the rule table, using wide integers.
  longint unsigned m_pc;
  bit              m_fault;
  longint unsigned m_cnt;

  function automatic longint unsigned model_target(longint unsigned pc, logic [1:0] sel,
      logic bt, logic [15:0] i16, logic [25:0] i26, logic [31:0] rs);
    longint unsigned p4 = (pc + 4) % (64'd1 << 32);
    longint          t;
    case (sel)
      2'd0: t = longint'(p4);
      2'd1: t = bt ? longint'(p4) + longint'($signed(i16)) * 4 : longint'(p4);
      2'd2: t = longint'((p4 / 268435456) * 268435456 + longint'(i26) * 4);
      default: t = longint'(rs);
    endcase
    if (t < 0) t = t + (longint'(1) << 32);
    return longint'(t) % (64'd1 << 32);
  endfunction

  always @(posedge clk) begin
    longint unsigned t;
    t = model_target(m_pc, npc_sel, br_taken, imm16, imm26, rs_val);
    if (reset) begin
      m_pc <= BASE; m_fault <= 1'b0; m_cnt <= 0;
    end else if (!m_fault && !stall) begin
      if (t % 4 == 0 && t >= BASE && t < BASE + 4 * WORDS) begin
        m_pc <= t; m_cnt <= (m_cnt + 1) % (64'd1 << 32);
      end else begin
        m_fault <= 1'b1;
      end
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (check_en) begin
      check32("cyc_pc", PC, m_pc[31:0]);
      check32("cyc_pc4", PC4, 32'(m_pc + 4));
      check32("cyc_fault", {31'b0, pc_fault}, {31'b0, m_fault});
`ifdef FETCH_PC_CNT_EN
      check32("cyc_cnt", fetch_cnt, m_cnt[31:0]);
`endif
    end
  end

  // One clock edge; inputs change only at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic bt,
      input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
    stall = st; npc_sel = sel; br_taken = bt; imm16 = i16; imm26 = i26; rs_val = rs;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 0, 0);
    do_reset();
    check_en = 1'b1;
    check32("rst_pc", PC, 32'h3000);
    check32("rst_pc4", PC4, 32'h3004);
    check32("rst_fault", {31'b0, pc_fault}, 32'd0);

    // sequential x3
    cyc(); check32("seq1", PC, 32'h3004);
    cyc(); check32("seq2", PC, 32'h3008);
    cyc(); check32("seq3", PC, 32'h300C);
`ifdef FETCH_PC_CNT_EN
    check32("cnt3", fetch_cnt, 32'd3);
`endif

    // branches from 3008
    drive(0, 2'b11, 0, 0, 0, 32'h3008); cyc(); check32("jr3008", PC, 32'h3008);
    drive(0, 2'b01, 1, 16'hFFFE, 0, 0); cyc(); check32("br_taken", PC, 32'h3004);
    drive(0, 2'b00, 0, 0, 0, 0);        cyc(); check32("seq_back", PC, 32'h3008);
    drive(0, 2'b01, 0, 16'hFFFE, 0, 0); cyc(); check32("br_not", PC, 32'h300C);
    drive(0, 2'b00, 0, 0, 0, 0);        cyc(); check32("seq3010", PC, 32'h3010);

    // jumps
    drive(0, 2'b10, 0, 0, 26'h0000C10, 0); cyc(); check32("j", PC, 32'h3040);
    drive(0, 2'b11, 0, 0, 0, 32'h3100);    cyc(); check32("jr", PC, 32'h3100);

    // window base is legal
    drive(0, 2'b11, 0, 0, 0, 32'h3000);    cyc(); check32("jr_base", PC, 32'h3000);
    drive(0, 2'b11, 0, 0, 0, 32'h3100);    cyc();

    // misaligned jump faults and freezes
    drive(0, 2'b11, 0, 0, 0, 32'h3002); cyc();
    check32("mis_pc", PC, 32'h3100);
    check32("mis_fault", {31'b0, pc_fault}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(i[0], i[1:0], 1, 16'h0010, 26'h0000C10, 32'h3200); cyc();
    end
    check32("frozen_pc", PC, 32'h3100);
    check32("frozen_fault", {31'b0, pc_fault}, 32'd1);
    drive(0, 2'b00, 0, 0, 0, 0);
    do_reset();
    check32("rst2_pc", PC, 32'h3000);
    check32("rst2_fault", {31'b0, pc_fault}, 32'd0);

    // below the window faults
    drive(0, 2'b11, 0, 0, 0, 32'h2FFC); cyc();
    check32("below_fault", {31'b0, pc_fault}, 32'd1);
    drive(0, 2'b00, 0, 0, 0, 0); do_reset();

    // top of window: stall then sequential wrap
    drive(0, 2'b11, 0, 0, 0, 32'h3FFC); cyc(); check32("top", PC, 32'h3FFC);
    drive(1, 2'b00, 0, 0, 0, 0); cyc(); cyc();
    check32("top_stall_pc", PC, 32'h3FFC);
    check32("top_stall_fault", {31'b0, pc_fault}, 32'd0);
    drive(0, 2'b00, 0, 0, 0, 0); cyc();
    check32("top_wrap_pc", PC, 32'h3FFC);
    check32("top_wrap_fault", {31'b0, pc_fault}, 32'd1);
    do_reset();

    // one past the top via jump register
    drive(0, 2'b11, 0, 0, 0, 32'h4000); cyc();
    check32("above_fault", {31'b0, pc_fault}, 32'd1);
    drive(0, 2'b00, 0, 0, 0, 0); do_reset();

    // reset in the middle of a stall
    drive(0, 2'b11, 0, 0, 0, 32'h3100); cyc();
    drive(1, 2'b11, 0, 0, 0, 32'h3200); cyc(); check32("stall_c1", PC, 32'h3100);
    reset = 1'b1; cyc(); reset = 1'b0;     check32("stall_c2", PC, 32'h3000);
    cyc(); check32("stall_c3", PC, 32'h3000);
    cyc(); check32("stall_c4", PC, 32'h3000);
    check32("stall_fault", {31'b0, pc_fault}, 32'd0);
`ifdef FETCH_PC_CNT_EN
    check32("stall_cnt", fetch_cnt, 32'd0);
`endif

    drive(0, 2'b00, 0, 0, 0, 0); cyc(); check32("after_stall", PC, 32'h3004);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
